dsopenhpsdr1_parser: RTL and testbench

- Downstream (PC->card) OpenHPSDR protocol-1 unpacker; the counterpart of the upstream packer.
- Consumes the UDP payload byte stream from the Ethernet receive path, one byte per cycle.
- Decodes start/stop and discovery requests, and the command/control (C&C) words of each 512-byte frame, presented on the command slave bus (cmd_addr/cmd_data/cmd_rqst).
- Forwards transmit I/Q samples to the TX FIFO.

---
 rtl/dsopenhpsdr1_parser_if.sv | 31 +++
 rtl/dsopenhpsdr1_parser.sv | 181 ++++++++++++++++++
 tb/tb_dsopenhpsdr1_parser.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsopenhpsdr1_parser_if.sv
// Bus bundle between the UDP receive path, the downstream parser and its consumers.
// The slave side is the parser; the master side drives the payload stream and the FIFO ready.
interface dsopenhpsdr1_parser_if;
    logic        udp_rx_active;
    logic [7:0]  udp_rx_data;
    logic        run;
    logic        wide_spectrum;
    logic        discovery;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        cmd_rqst;
    logic        cmd_ptt;
    logic [31:0] ds_tdata;
    logic        ds_tvalid;
    logic        ds_tready;
    logic        ds_overflow;
    logic        seq_err;
    logic        watchdog_down;

    modport slave (
        input  udp_rx_active, udp_rx_data, ds_tready,
        output run, wide_spectrum, discovery, cmd_addr, cmd_data, cmd_rqst, cmd_ptt,
               ds_tdata, ds_tvalid, ds_overflow, seq_err, watchdog_down
    );

    modport master (
        output udp_rx_active, udp_rx_data, ds_tready,
        input  run, wide_spectrum, discovery, cmd_addr, cmd_data, cmd_rqst, cmd_ptt,
               ds_tdata, ds_tvalid, ds_overflow, seq_err, watchdog_down
    );
endinterface

// File: rtl/dsopenhpsdr1_parser.sv
// Downstream OpenHPSDR protocol-1 unpacker: decodes start/stop, discovery, C&C words
// and TX I/Q samples from the UDP payload byte stream (one byte per cycle).
module dsopenhpsdr1_parser #(
    parameter bit CHECK_SYNC = 1'b1,
    parameter bit SEQ_CHECK  = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    dsopenhpsdr1_parser_if.slave bus
);
    typedef enum logic [2:0] {
        StWaitIdle, StHdr, StSeq, StSync, StCc, StSample, StDiscard
    } state_e;

    state_e      state_q;
    logic [10:0] cnt_q;
    logic [2:0]  sub_q;
    logic [23:0] seq_rx_q;
    logic [31:0] seq_exp_q;
    logic [6:0]  c0_q;
    logic [23:0] cc_q;
    logic [23:0] smp_q;

    logic        run_q, wide_q, disc_q, rqst_q, ptt_q, tvalid_q, seq_err_q, wd_q;
    logic [5:0]  addr_q;
    logic [31:0] data_q, tdata_q;

    logic        active;
    logic [7:0]  b;
    logic [31:0] seq_full;
    logic        frame_end, pkt_end;

    assign active    = bus.udp_rx_active;
    assign b         = bus.udp_rx_data;
    assign seq_full  = {seq_rx_q, b};
    assign frame_end = (cnt_q == 11'd519);
    assign pkt_end   = (cnt_q == 11'd1031);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StWaitIdle;
            cnt_q     <= '0;
            sub_q     <= '0;
            seq_rx_q  <= '0;
            seq_exp_q <= '0;
            c0_q      <= '0;
            cc_q      <= '0;
            smp_q     <= '0;
            run_q     <= 1'b0;
            wide_q    <= 1'b0;
            disc_q    <= 1'b0;
            rqst_q    <= 1'b0;
            ptt_q     <= 1'b0;
            tvalid_q  <= 1'b0;
            seq_err_q <= 1'b0;
            wd_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            tdata_q   <= '0;
        end else begin
            disc_q    <= 1'b0;
            rqst_q    <= 1'b0;
            tvalid_q  <= 1'b0;
            seq_err_q <= 1'b0;
            if (state_q == StWaitIdle) begin
                // A packet is only recognised after an idle gap.
                if (!active) begin
                    state_q <= StHdr;
                    cnt_q   <= '0;
                end
            end else if (!active) begin
                // Early termination drops any partial sample or C&C word.
                state_q <= StHdr;
                cnt_q   <= '0;
                sub_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 11'd1;
                case (state_q)
                    StHdr: begin
                        case (cnt_q)
                            11'd0: if (b != 8'hEF) state_q <= StWaitIdle;
                            11'd1: if (b != 8'hFE) state_q <= StWaitIdle;
                            11'd2: begin
                                case (b)
                                    8'h01: state_q <= StSeq;
                                    8'h02: begin
                                        disc_q  <= 1'b1;
                                        state_q <= StWaitIdle;
                                    end
                                    8'h04: state_q <= StHdr;
                                    default: state_q <= StWaitIdle;
                                endcase
                            end
                            11'd3: begin
                                run_q   <= b[0];
                                wide_q  <= b[1];
                                state_q <= StWaitIdle;
                            end
                            default: state_q <= StWaitIdle;
                        endcase
                    end
                    StSeq: begin
                        if (cnt_q == 11'd7) begin
                            seq_err_q <= SEQ_CHECK && (seq_full != seq_exp_q);
                            seq_exp_q <= seq_full + 32'd1;
                            sub_q     <= '0;
                            state_q   <= StSync;
                        end else if (cnt_q[2]) begin
                            seq_rx_q <= {seq_rx_q[15:0], b};
                        end
                    end
                    StSync: begin
                        if (CHECK_SYNC && (b != 8'h7F)) begin
                            state_q <= StDiscard;
                        end else if (sub_q == 3'd2) begin
                            sub_q   <= '0;
                            state_q <= StCc;
                        end else begin
                            sub_q <= sub_q + 3'd1;
                        end
                    end
                    StCc: begin
                        sub_q <= sub_q + 3'd1;
                        case (sub_q)
                            3'd0: c0_q <= b[6:0];
                            3'd4: begin
                                addr_q  <= c0_q[6:1];
                                ptt_q   <= c0_q[0];
                                data_q  <= {cc_q, b};
                                rqst_q  <= 1'b1;
                                sub_q   <= '0;
                                state_q <= StSample;
                            end
                            default: cc_q <= {cc_q[15:0], b};
                        endcase
                    end
                    StSample: begin
                        sub_q <= sub_q + 3'd1;
                        if (sub_q == 3'd7) begin
                            tdata_q  <= {smp_q, b};
                            tvalid_q <= 1'b1;
                            if (pkt_end) begin
                                wd_q    <= ~wd_q;
                                state_q <= StWaitIdle;
                            end else if (frame_end) begin
                                sub_q   <= '0;
                                state_q <= StSync;
                            end
                        end else if (sub_q[2]) begin
                            // L/R audio bytes (sub 0..3) are dropped; I1 I0 Q1 are kept.
                            smp_q <= {smp_q[15:0], b};
                        end
                    end
                    StDiscard: begin
                        if (pkt_end) begin
                            wd_q    <= ~wd_q;
                            state_q <= StWaitIdle;
                        end else if (frame_end) begin
                            sub_q   <= '0;
                            state_q <= StSync;
                        end
                    end
                    default: state_q <= StWaitIdle;
                endcase
            end
        end
    end

    assign bus.run           = run_q;
    assign bus.wide_spectrum = wide_q;
    assign bus.discovery     = disc_q;
    assign bus.cmd_addr      = addr_q;
    assign bus.cmd_data      = data_q;
    assign bus.cmd_rqst      = rqst_q;
    assign bus.cmd_ptt       = ptt_q;
    assign bus.ds_tdata      = tdata_q;
    assign bus.ds_tvalid     = tvalid_q;
    assign bus.ds_overflow   = tvalid_q & ~bus.ds_tready;
    assign bus.seq_err       = seq_err_q;
    assign bus.watchdog_down = wd_q;
endmodule

// File: tb/tb_dsopenhpsdr1_parser.sv
// Bench for dsopenhpsdr1_parser: expected C&C words and samples are queued as bytes are
// driven and compared by a negedge monitor when the parser emits them.
module tb_dsopenhpsdr1_parser;
    logic clk = 1'b0;
    logic rst = 1'b1;
    dsopenhpsdr1_parser_if bus();

    dsopenhpsdr1_parser #(.CHECK_SYNC(1'b1), .SEQ_CHECK(1'b1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cmd_seen, smp_seen, disc_cnt, disc_cyc, seqerr_cnt, ovf_cnt;
    logic [38:0] exp_cmd[$];
    logic [31:0] exp_smp[$];
    logic [38:0] mon_cmd;
    logic [31:0] mon_smp;
    logic [7:0]  pkt[0:1031];
    bit          frame_ok[2];
    logic        wd_model = 1'b0;
    logic [78:0] outs;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.cmd_rqst) begin
            cmd_seen++;
            checks++;
            if (exp_cmd.size() == 0) begin
                errors++;
                $display("FAIL cmd_unexpected: got addr=%h ptt=%b data=%h, required no cmd_rqst",
                         bus.cmd_addr, bus.cmd_ptt, bus.cmd_data);
            end else begin
                mon_cmd = exp_cmd.pop_front();
                if ({bus.cmd_addr, bus.cmd_ptt, bus.cmd_data} !== mon_cmd) begin
                    errors++;
                    $display("FAIL cmd_word: got %h, required %h",
                             {bus.cmd_addr, bus.cmd_ptt, bus.cmd_data}, mon_cmd);
                end
            end
        end
        if (bus.ds_tvalid) begin
            smp_seen++;
            checks++;
            if (exp_smp.size() == 0) begin
                errors++;
                $display("FAIL sample_unexpected: got %h, required no ds_tvalid", bus.ds_tdata);
            end else begin
                mon_smp = exp_smp.pop_front();
                if (bus.ds_tdata !== mon_smp) begin
                    errors++;
                    $display("FAIL sample_data: got %h, required %h", bus.ds_tdata, mon_smp);
                end
            end
        end
        if (bus.discovery) begin
            disc_cnt++;
            disc_cyc = cyc;
        end
        if (bus.seq_err) seqerr_cnt++;
        if (bus.ds_overflow) ovf_cnt++;
    end

    task automatic clear_counts();
        cmd_seen = 0; smp_seen = 0; disc_cnt = 0; disc_cyc = -1; seqerr_cnt = 0; ovf_cnt = 0;
    endtask

    task automatic drive(input logic [7:0] b);
        @(posedge clk); #1;
        bus.udp_rx_active = 1'b1;
        bus.udp_rx_data   = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.udp_rx_active = 1'b0;
            bus.udp_rx_data   = 8'h00;
            bus.ds_tready     = 1'b1;
        end
    endtask

    task automatic build_pkt(input logic [31:0] seq, input logic [7:0] c0a,
                             input logic [31:0] da, input logic [7:0] c0b,
                             input logic [31:0] db);
        logic [15:0] iv, qv;
        logic [31:0] d;
        int base, o, k;
        pkt[0] = 8'hEF; pkt[1] = 8'hFE; pkt[2] = 8'h01; pkt[3] = 8'h02;
        pkt[4] = seq[31:24]; pkt[5] = seq[23:16]; pkt[6] = seq[15:8]; pkt[7] = seq[7:0];
        for (int f = 0; f < 2; f++) begin
            base = 8 + 512 * f;
            d = (f == 0) ? da : db;
            pkt[base] = 8'h7F; pkt[base + 1] = 8'h7F; pkt[base + 2] = 8'h7F;
            pkt[base + 3] = (f == 0) ? c0a : c0b;
            pkt[base + 4] = d[31:24]; pkt[base + 5] = d[23:16];
            pkt[base + 6] = d[15:8];  pkt[base + 7] = d[7:0];
            for (int s = 0; s < 63; s++) begin
                o  = base + 8 + 8 * s;
                k  = 63 * f + s;
                iv = 16'h1000 + 16'(k);
                qv = 16'hF000 - 16'(3 * k);
                pkt[o]     = 8'hA5;      pkt[o + 1] = 8'h5A;
                pkt[o + 2] = 8'hC3;      pkt[o + 3] = 8'h3C;
                pkt[o + 4] = iv[15:8];   pkt[o + 5] = iv[7:0];
                pkt[o + 6] = qv[15:8];   pkt[o + 7] = qv[7:0];
            end
        end
        frame_ok[0] = 1'b1;
        frame_ok[1] = 1'b1;
    endtask

    // Drives pkt[first..last-1]; when track is set, queues what each byte should produce.
    task automatic send(input int first, input int last, input bit track, input bit ovf);
        int f, o;
        logic [7:0] c0;
        for (int i = first; i < last; i++) begin
            @(posedge clk); #1;
            bus.udp_rx_active = 1'b1;
            bus.udp_rx_data   = pkt[i];
            bus.ds_tready     = !(ovf && i >= 24 && i <= 56);
            if (track && i >= 8) begin
                f = (i >= 520) ? 1 : 0;
                o = i - 8 - 512 * f;
                if (frame_ok[f]) begin
                    if (o == 7) begin
                        c0 = pkt[i - 4];
                        exp_cmd.push_back({c0[6:1], c0[0], pkt[i - 3], pkt[i - 2],
                                           pkt[i - 1], pkt[i]});
                    end
                    if (o >= 8 && ((o - 8) % 8) == 7)
                        exp_smp.push_back({pkt[i - 3], pkt[i - 2], pkt[i - 1], pkt[i]});
                end
            end
            if (track && i == 1031) wd_model = ~wd_model;
        end
    endtask

    task automatic test_reset();
        #2;
        outs = {bus.run, bus.wide_spectrum, bus.discovery, bus.cmd_addr, bus.cmd_data,
                bus.cmd_rqst, bus.cmd_ptt, bus.ds_tdata, bus.ds_tvalid, bus.ds_overflow,
                bus.seq_err, bus.watchdog_down};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0", outs);
        end
        idle(3);
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_start_stop();
        drive(8'hEF); drive(8'hFE); drive(8'h04); drive(8'h03);
        idle(1);
        @(negedge clk);
        checks++;
        if ({bus.run, bus.wide_spectrum} !== 2'b11) begin
            errors++;
            $display("FAIL start_run_wide: got %b, required 11", {bus.run, bus.wide_spectrum});
        end
        idle(2);
        drive(8'hEF); drive(8'hFE); drive(8'h04); drive(8'h00);
        idle(1);
        @(negedge clk);
        checks++;
        if ({bus.run, bus.wide_spectrum} !== 2'b00) begin
            errors++;
            $display("FAIL stop_run_wide: got %b, required 00", {bus.run, bus.wide_spectrum});
        end
        idle(2);
    endtask

    task automatic test_discovery();
        int exp_cyc;
        clear_counts();
        drive(8'hEF); drive(8'hFE); drive(8'h02);
        exp_cyc = cyc + 1;
        repeat (60) drive(8'h00);
        idle(3);
        checks++;
        if (disc_cnt != 1) begin
            errors++;
            $display("FAIL discovery_count: got %0d, required 1", disc_cnt);
        end
        checks++;
        if (disc_cyc != exp_cyc) begin
            errors++;
            $display("FAIL discovery_timing: got cycle %0d, required %0d", disc_cyc, exp_cyc);
        end
        checks++;
        if (cmd_seen != 0) begin
            errors++;
            $display("FAIL discovery_no_cmd: got %0d cmd_rqst, required 0", cmd_seen);
        end
    endtask

    task automatic test_data_packet();
        clear_counts();
        build_pkt(32'd0, 8'h13, 32'h12345678, 8'h00, 32'hA1B2C3D4);
        send(0, 1032, 1'b1, 1'b0);
        idle(4);
        checks++;
        if (cmd_seen != 2 || exp_cmd.size() != 0) begin
            errors++;
            $display("FAIL data_cmd_count: got %0d seen/%0d pending, required 2/0",
                     cmd_seen, exp_cmd.size());
        end
        checks++;
        if (smp_seen != 126 || exp_smp.size() != 0) begin
            errors++;
            $display("FAIL data_sample_count: got %0d seen/%0d pending, required 126/0",
                     smp_seen, exp_smp.size());
        end
        checks++;
        if (bus.watchdog_down !== wd_model) begin
            errors++;
            $display("FAIL data_watchdog: got %b, required %b", bus.watchdog_down, wd_model);
        end
        checks++;
        if (seqerr_cnt != 0 || ovf_cnt != 0) begin
            errors++;
            $display("FAIL data_no_errors: got seq_err=%0d ovf=%0d, required 0/0",
                     seqerr_cnt, ovf_cnt);
        end
    endtask

    task automatic test_sequence();
        logic [31:0] seqs[3];
        int          exp_err[3];
        seqs = '{32'd1, 32'd3, 32'd4};
        exp_err = '{0, 1, 0};
        for (int p = 0; p < 3; p++) begin
            clear_counts();
            build_pkt(seqs[p], 8'h02, 32'h0000_0010 + p, 8'h04, 32'hDEAD_0000 + p);
            idle(2);
            send(0, 1032, 1'b1, 1'b0);
            idle(4);
            checks++;
            if (seqerr_cnt != exp_err[p]) begin
                errors++;
                $display("FAIL seq_err_%0d: got %0d pulses, required %0d",
                         seqs[p], seqerr_cnt, exp_err[p]);
            end
        end
        checks++;
        if (exp_cmd.size() != 0 || exp_smp.size() != 0) begin
            errors++;
            $display("FAIL seq_pending: got %0d/%0d pending, required 0/0",
                     exp_cmd.size(), exp_smp.size());
        end
    endtask

    task automatic test_bad_sync();
        clear_counts();
        build_pkt(32'd5, 8'h2B, 32'hCAFEF00D, 8'h05, 32'h01020304);
        pkt[9] = 8'h7E;
        frame_ok[0] = 1'b0;
        idle(2);
        send(0, 1032, 1'b1, 1'b0);
        idle(4);
        checks++;
        if (cmd_seen != 1 || smp_seen != 63) begin
            errors++;
            $display("FAIL bad_sync_counts: got cmd=%0d smp=%0d, required 1/63",
                     cmd_seen, smp_seen);
        end
        checks++;
        if (exp_cmd.size() != 0 || exp_smp.size() != 0) begin
            errors++;
            $display("FAIL bad_sync_pending: got %0d/%0d pending, required 0/0",
                     exp_cmd.size(), exp_smp.size());
        end
    endtask

    task automatic test_early_term();
        clear_counts();
        build_pkt(32'd6, 8'h11, 32'h55AA55AA, 8'h22, 32'h66776677);
        idle(2);
        send(0, 300, 1'b1, 1'b0);
        idle(4);
        checks++;
        if (cmd_seen != 1 || smp_seen != 35 || exp_smp.size() != 0) begin
            errors++;
            $display("FAIL early_counts: got cmd=%0d smp=%0d pending=%0d, required 1/35/0",
                     cmd_seen, smp_seen, exp_smp.size());
        end
        checks++;
        if (bus.watchdog_down !== wd_model) begin
            errors++;
            $display("FAIL early_watchdog: got %b, required %b", bus.watchdog_down, wd_model);
        end
        clear_counts();
        build_pkt(32'd7, 8'h33, 32'h89ABCDEF, 8'h44, 32'h76543210);
        send(0, 1032, 1'b1, 1'b0);
        idle(4);
        checks++;
        if (cmd_seen != 2 || smp_seen != 126 || seqerr_cnt != 0) begin
            errors++;
            $display("FAIL early_next_pkt: got cmd=%0d smp=%0d seq_err=%0d, required 2/126/0",
                     cmd_seen, smp_seen, seqerr_cnt);
        end
        checks++;
        if (bus.watchdog_down !== wd_model) begin
            errors++;
            $display("FAIL early_next_watchdog: got %b, required %b",
                     bus.watchdog_down, wd_model);
        end
    endtask

    task automatic test_overflow();
        clear_counts();
        build_pkt(32'd8, 8'h07, 32'h0BADBEEF, 8'h09, 32'h13572468);
        idle(2);
        send(0, 1032, 1'b1, 1'b1);
        idle(4);
        checks++;
        if (ovf_cnt != 5) begin
            errors++;
            $display("FAIL overflow_count: got %0d, required 5", ovf_cnt);
        end
        checks++;
        if (smp_seen != 126 || exp_smp.size() != 0) begin
            errors++;
            $display("FAIL overflow_samples: got %0d seen/%0d pending, required 126/0",
                     smp_seen, exp_smp.size());
        end
    endtask

    task automatic test_reset_mid();
        drive(8'hEF); drive(8'hFE); drive(8'h04); drive(8'h01);
        idle(2);
        build_pkt(32'd9, 8'h2B, 32'hFEEDFACE, 8'h05, 32'h0F0F0F0F);
        send(0, 601, 1'b1, 1'b0);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        outs = {bus.run, bus.wide_spectrum, bus.discovery, bus.cmd_addr, bus.cmd_data,
                bus.cmd_rqst, bus.cmd_ptt, bus.ds_tdata, bus.ds_tvalid, bus.ds_overflow,
                bus.seq_err, bus.watchdog_down};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %h, required 0", outs);
        end
        checks++;
        if (exp_cmd.size() != 0 || exp_smp.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_pending: got %0d/%0d pending, required 0/0",
                     exp_cmd.size(), exp_smp.size());
        end
        wd_model = 1'b0;
        clear_counts();
        send(601, 603, 1'b0, 1'b0);
        rst = 1'b0;
        send(603, 1032, 1'b0, 1'b0);
        idle(4);
        checks++;
        if (cmd_seen != 0 || smp_seen != 0 || bus.run !== 1'b0 || bus.cmd_data !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_ignored: got cmd=%0d smp=%0d run=%b data=%h, required 0/0/0/0",
                     cmd_seen, smp_seen, bus.run, bus.cmd_data);
        end
        clear_counts();
        build_pkt(32'd0, 8'h3F, 32'h24681357, 8'h06, 32'h11223344);
        send(0, 1032, 1'b1, 1'b0);
        idle(4);
        checks++;
        if (seqerr_cnt != 0 || cmd_seen != 2 || smp_seen != 126) begin
            errors++;
            $display("FAIL post_reset_pkt: got seq_err=%0d cmd=%0d smp=%0d, required 0/2/126",
                     seqerr_cnt, cmd_seen, smp_seen);
        end
        checks++;
        if (bus.watchdog_down !== wd_model) begin
            errors++;
            $display("FAIL post_reset_watchdog: got %b, required %b",
                     bus.watchdog_down, wd_model);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL time_limit: got simulation still running, required completion");
        $fatal(1, "time limit");
    end

    initial begin
        bus.udp_rx_active = 1'b0;
        bus.udp_rx_data   = 8'h00;
        bus.ds_tready     = 1'b1;
        clear_counts();
        test_reset();
        test_start_stop();
        test_discovery();
        test_data_packet();
        test_sequence();
        test_bad_sync();
        test_early_term();
        test_overflow();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
